// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor: per-channel HDLC flag/abort/stuff/idle pulse detectors with saturating event counters.
// Define HDLC_MON_IRQ_EN to build the sticky per-channel interrupt logic; otherwise o_irq is tied low.
module hdlc_line_monitor #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int IDLE_GAP = 8,
  parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_line,
  input  logic [CHANNELS-1:0] i_frame_active,
  input  logic [CHANNELS-1:0] i_abort_req,
  input  logic                i_cnt_clr,
  input  logic [CHW-1:0]      i_rd_chan,
  input  logic [1:0]          i_rd_sel,
  output logic [CNT_W-1:0]    o_rd_data,
  output logic [CHANNELS-1:0] o_flag_det,
  output logic [CHANNELS-1:0] o_abort_det,
  output logic [CHANNELS-1:0] o_stuff_err,
  output logic [CHANNELS-1:0] o_idle_err,
  input  logic [CHANNELS-1:0] i_irq_mask,
  input  logic                i_irq_ack,
  output logic                o_irq
);
  localparam int IW = $clog2(IDLE_GAP + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_GAP);
  // Only the last seven bits matter: the eighth flag bit is the incoming sample.
  logic [6:0]          r_hist [CHANNELS];
  logic [2:0]          r_run  [CHANNELS];
  logic [IW-1:0]       r_idle [CHANNELS];
  logic [CNT_W-1:0]    r_cnt  [CHANNELS][4];
  logic [3:0]          w_ev   [CHANNELS];
  logic [CHANNELS-1:0] r_flag, r_abort, r_stuff, r_idle_err;
  logic [CHANNELS-1:0] w_flag, w_abort, w_stuff, w_idle_err;
  logic [CNT_W-1:0]    r_rd_data, w_rd_data;
  always_comb begin
    w_flag     = '0;
    w_abort    = '0;
    w_stuff    = '0;
    w_idle_err = '0;
    w_ev       = '{default: '0};
    for (int c = 0; c < CHANNELS; c++) begin
      w_flag[c]     = {r_hist[c], i_line[c]} == 8'h7E;
      w_abort[c]    = i_frame_active[c] && i_line[c] && r_run[c] == 3'd6;
      w_stuff[c]    = i_frame_active[c] && !i_abort_req[c] && i_line[c] && r_run[c] == 3'd5;
      w_idle_err[c] = !i_frame_active[c] && r_idle[c] == IDLE_MAX && !i_line[c];
      w_ev[c]       = {r_idle_err[c], r_stuff[c], r_abort[c], r_flag[c]};
    end
  end
  // Channels outside CHANNELS fall through to zero.
  always_comb begin
    w_rd_data = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (i_rd_chan == CHW'(c)) w_rd_data = r_cnt[c][i_rd_sel];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flag     <= '0;
      r_abort    <= '0;
      r_stuff    <= '0;
      r_idle_err <= '0;
      r_rd_data  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_hist[c] <= 7'h7F;
        r_run[c]  <= '0;
        r_idle[c] <= IDLE_MAX;
        for (int k = 0; k < 4; k++) r_cnt[c][k] <= '0;
      end
    end else begin
      r_flag     <= w_flag;
      r_abort    <= w_abort;
      r_stuff    <= w_stuff;
      r_idle_err <= w_idle_err;
      r_rd_data  <= w_rd_data;
      for (int c = 0; c < CHANNELS; c++) begin
        r_hist[c] <= {r_hist[c][5:0], i_line[c]};
        r_run[c]  <= !i_line[c] ? 3'd0 : (r_run[c] == 3'd7) ? 3'd7 : r_run[c] + 3'd1;
        r_idle[c] <= i_frame_active[c] ? '0 : (r_idle[c] == IDLE_MAX) ? IDLE_MAX : r_idle[c] + IW'(1);
        for (int k = 0; k < 4; k++)
          if (i_cnt_clr) r_cnt[c][k] <= '0;
          else if (w_ev[c][k] && r_cnt[c][k] != '1) r_cnt[c][k] <= r_cnt[c][k] + CNT_W'(1);
      end
    end
  end
  assign o_rd_data   = r_rd_data;
  assign o_flag_det  = r_flag;
  assign o_abort_det = r_abort;
  assign o_stuff_err = r_stuff;
  assign o_idle_err  = r_idle_err;
`ifdef HDLC_MON_IRQ_EN
  logic [CHANNELS-1:0] r_pend, w_pend;
  logic                r_irq;
  // A new event on the ack edge keeps its pending bit.
  assign w_pend = (r_pend & {CHANNELS{!i_irq_ack}}) | r_flag | r_abort | r_stuff | r_idle_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= w_pend;
      r_irq  <= |(w_pend & i_irq_mask);
    end
  end
  assign o_irq = r_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = ^{i_irq_mask, i_irq_ack};
  assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb_hdlc_line_monitor: directed plus randomized checks of hdlc_line_monitor against a bit-history reference model.
module tb_hdlc_line_monitor;
  localparam int CH = 3, CW = 2, GAP = 8, CHW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0] line, fa, areq, mask;
  logic clr, ack;
  logic [CHW-1:0] rd_chan;
  logic [1:0] rd_sel;
  logic [CW-1:0] rd_data;
  logic [CH-1:0] flag, abrt, stuff, idle;
  logic irq;
  int n_chk = 0, n_fail = 0;
  int ones[CH], gap[CH], last[CH], cnt[CH][4];
  logic [3:0] pulse[CH];
  logic [CH-1:0] pend;
  logic [CW-1:0] rd_exp;
  logic irq_exp;

  always #5 clk = ~clk;

  hdlc_line_monitor #(.CHANNELS(CH), .CNT_W(CW), .IDLE_GAP(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_line(line), .i_frame_active(fa), .i_abort_req(areq),
    .i_cnt_clr(clr), .i_rd_chan(rd_chan), .i_rd_sel(rd_sel), .o_rd_data(rd_data),
    .o_flag_det(flag), .o_abort_det(abrt), .o_stuff_err(stuff), .o_idle_err(idle),
    .i_irq_mask(mask), .i_irq_ack(ack), .o_irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ones[c] = 0;
      gap[c] = GAP;
      last[c] = 8'hFF;
      pulse[c] = '0;
      for (int k = 0; k < 4; k++) cnt[c][k] = 0;
    end
    pend = '0;
    rd_exp = '0;
    irq_exp = 1'b0;
  endtask

  task automatic step();
    logic [3:0] det[CH];
    logic [CH-1:0] pn, ef, ea, es, ei;
    for (int c = 0; c < CH; c++) begin
      int b = int'(line[c]);
      det[c][0] = (((last[c] << 1) | b) & 8'hFF) == 8'h7E;
      det[c][1] = fa[c] && b == 1 && ones[c] == 6;
      det[c][2] = fa[c] && !areq[c] && b == 1 && ones[c] == 5;
      det[c][3] = !fa[c] && gap[c] >= GAP && b == 0;
    end
    rd_exp = '0;
    if (int'(rd_chan) < CH) rd_exp = CW'(cnt[rd_chan][rd_sel]);
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 4; k++)
        if (clr) cnt[c][k] = 0;
        else if (pulse[c][k] && cnt[c][k] < (1 << CW) - 1) cnt[c][k]++;
`ifdef HDLC_MON_IRQ_EN
    for (int c = 0; c < CH; c++) pn[c] = (pend[c] && !ack) || (pulse[c] != 0);
    pend = pn;
    irq_exp = |(pn & mask);
`else
    pn = '0;
    irq_exp = 1'b0;
`endif
    for (int c = 0; c < CH; c++) begin
      ones[c] = line[c] ? ones[c] + 1 : 0;
      gap[c] = fa[c] ? 0 : gap[c] + 1;
      last[c] = ((last[c] << 1) | int'(line[c])) & 8'hFF;
      pulse[c] = det[c];
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      ef[c] = pulse[c][0];
      ea[c] = pulse[c][1];
      es[c] = pulse[c][2];
      ei[c] = pulse[c][3];
    end
    check("flag_det", flag, ef);
    check("abort_det", abrt, ea);
    check("stuff_err", stuff, es);
    check("idle_err", idle, ei);
    check("rd_data", rd_data, rd_exp);
    check("irq", irq, irq_exp);
  endtask

  task automatic send(input int ch, input logic [31:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      line[ch] = pat[i];
      step();
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_flag", flag, 0);
    check("rst_abort", abrt, 0);
    check("rst_stuff", stuff, 0);
    check("rst_idle", idle, 0);
    check("rst_rd", rd_data, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    line = '1; fa = '0; areq = '0; mask = '0; clr = 1'b0; ack = 1'b0;
    rd_chan = '0; rd_sel = '0;
    model_reset();
    #12;
    check("por_flag", flag, 0);
    check("por_rd", rd_data, 0);
    check("por_irq", irq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    // Flag on channel 0 outside a frame
    send(0, 32'b01111110, 8);
    check("flag_pulse", flag[0], 1);
    line[0] = 1'b1;
    step();
    check("flag_width", flag[0], 0);
    step();
    check("flag_cnt", rd_data, 1);
    // Stuffed data accepted, then a stuff violation and an abort
    fa[0] = 1'b1;
    send(0, 32'b01111101, 8);
    line[0] = 1'b0;
    step();
    send(0, 32'b111111, 6);
    check("stuff_6th", stuff[0], 1);
    check("no_abort_6th", abrt[0], 0);
    send(0, 32'b1, 1);
    check("abort_7th", abrt[0], 1);
    // Abort while the transmitter signals it: no stuff error
    clr = 1'b1;
    step();
    clr = 1'b0;
    areq[0] = 1'b1;
    line[0] = 1'b0;
    step();
    send(0, 32'hFF, 8);
    rd_sel = 2'd1;
    step();
    check("abort_cnt", rd_data, 1);
    rd_sel = 2'd2;
    step();
    check("stuff_cnt", rd_data, 0);
    fa[0] = 1'b0; areq[0] = 1'b0;
    // Idle enforcement on channel 1
    fa[1] = 1'b1;
    step();
    fa[1] = 1'b0;
    send(1, 32'b11110, 5);
    check("idle_early", idle[1], 0);
    send(1, 32'b1110, 4);
    check("idle_late", idle[1], 1);
    line[1] = 1'b1;
    step();
    // Saturation and clear on channel 2
    clr = 1'b1;
    step();
    clr = 1'b0;
    send(2, 32'b0, 1);
    repeat (5) send(2, 32'b1111110, 7);
    rd_chan = 2'd2; rd_sel = 2'd0;
    step();
    step();
    check("flag_sat", rd_data, 3);
    send(2, 32'b1111110, 7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("clr_wins", rd_data, 0);
    rd_chan = 2'd3;
    step();
    check("rd_oob", rd_data, 0);
    // Interrupt masking and acknowledge
    line = '1; mask = 3'b010;
    repeat (3) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("irq_idle", irq, 0);
    fa[0] = 1'b1; areq[0] = 1'b1;
    send(0, 32'b01111110, 8);
    step();
    check("irq_masked", irq, 0);
    fa[1] = 1'b1; areq[1] = 1'b1;
    send(1, 32'b01111110, 8);
    check("irq_before", irq, 0);
    step();
`ifdef HDLC_MON_IRQ_EN
    check("irq_set", irq, 1);
`else
    check("irq_off", irq, 0);
`endif
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("irq_ack", irq, 0);
    // Reset in the middle of a frame
    fa = '1; areq = '0;
    send(0, 32'b0111, 4);
    do_reset();
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        line[c] = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 19) == 0) fa[c] = ~fa[c];
        areq[c] = ($urandom_range(0, 9) == 0);
      end
      clr = ($urandom_range(0, 49) == 0);
      ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) mask = CH'($urandom);
      rd_chan = CHW'($urandom_range(0, 3));
      rd_sel = 2'($urandom_range(0, 3));
      step();
      if (i == 1500) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hdlc_line_monitor.md
# hdlc_line_monitor

Synthesizable, parametrised multi-channel HDLC serial-line monitor for the HDLC controller. Each channel watches one serial bit stream and its frame-active qualifier. It flags opening/closing flags, aborts, zero-insertion (bit-stuffing) violations and idle-pattern violations as single-cycle pulses, and counts each event type per channel in saturating counters that software can read. It sits beside the Tx/Rx serial paths for in-silicon monitoring. It is also reused as a scoreboard front-end in the bench.

## Interface
- CHANNELS, 4, number of monitored lines (≥1)
- CNT_W, 8, width of each event counter
- IDLE_GAP, 8, cycles after FrameActive falls before an all-ones idle line is enforced (≥1)
- CHW, derived, width of RdChan; CHW = max(1, clog2(CHANNELS))

Ports:
- Clk  in  1  clock; all sampling on rising edge
- Rst  in  1  reset; asynchronous and active-low (Rst=0 resets)
- Line  in  CHANNELS  serial bit per channel, one bit per Clk
- FrameActive  in  CHANNELS  high only for bits strictly between the opening and closing flag
- AbortReq  in  CHANNELS  transmitter is sending an abort; suppresses StuffErr
- CntClr  in  1  synchronous clear of all counters
- RdChan  in  CHW  counter read channel
- RdSel  in  2  counter read select: 0 flag, 1 abort, 2 stuff error, 3 idle error
- RdData  out  CNT_W  registered counter value
- FlagDet  out  CHANNELS  one-cycle pulse per detected flag
- AbortDet  out  CHANNELS  one-cycle pulse per abort inside a frame
- StuffErr  out  CHANNELS  one-cycle pulse per zero-insertion violation
- IdleErr  out  CHANNELS  one-cycle pulse per idle violation
- IrqMask  in  CHANNELS  per-channel interrupt enable
- IrqAck  in  1  clears all pending interrupt bits
- Irq  out  1  interrupt request

## Operation
The following state is kept per channel c, all updated on the rising Clk edge:
- hist[7:0] <= {hist[6:0], Line[c]}; reset 8'hFF.
- run[2:0] is the consecutive-ones count, saturating at 7. Line=1 increments it; Line=0 sets it to 0. Reset value is 0.
- idle[..] counts cycles since FrameActive was last high, saturating at IDLE_GAP. FrameActive=1 sets it to 0. Reset value is IDLE_GAP.

Detectors, each registered into its pulse output on the next edge:
- **Flag:** {hist[6:0], Line} == 8'h7E sets FlagDet. This is independent of FrameActive.
- **Abort:** FrameActive && Line && run==6 sets AbortDet, i.e. the 7th consecutive one. It fires once per run.
- **Stuff:** FrameActive && !AbortReq && Line && run==5 sets StuffErr, i.e. a 6th one inside a frame.
- **Idle:** !FrameActive && idle==IDLE_GAP && !Line sets IdleErr. It fires on every violating bit.

Counters (4 per channel, CNT_W each):
- Each counter increments in the cycle after its pulse is high.
- Counters saturate at all-ones and never wrap.
- CntClr=1 zeroes every counter. An increment coinciding with CntClr is lost.
- RdData <= cnt[RdChan][RdSel] every cycle. RdChan ≥ CHANNELS returns 0.

Reset:
- Rst low at any time, including mid-frame, asynchronously forces all state to its reset value.
- All pulses, RdData, every counter and Irq go to 0.
- Monitoring resumes on the first edge after Rst rises, with the line treated as idle.

## Timing
- Pulse latency: 1 Clk after the edge that samples the triggering bit. Pulse width is exactly 1 cycle.
- Counter latency: a counter reflects an event 2 edges after the trigger bit. RdData adds 1 more edge.
- Simultaneous events on one channel (e.g. StuffErr and FlagDet) are all reported, each in its own counter.
- No handshake exists. Inputs are assumed synchronous to Clk.

## Configuration
- HDLC_MON_IRQ_EN defined:
  - A per-channel sticky pend[c] is set by any of the four pulses on channel c.
  - IrqAck clears all pend bits. A set on the same edge as IrqAck wins.
  - Irq = |(pend & IrqMask), driven from registers with no combinational input path.
  - pend resets to 0.
- HDLC_MON_IRQ_EN undefined:
  - No pend registers exist and Irq is constant 0.
  - IrqMask and IrqAck are ignored.

## Test plan
- Flag detection: drive channel 0 with 0,1,1,1,1,1,1,0 while FrameActive=0. FlagDet[0] pulses exactly 1 cycle after the last 0. The flag counter reads 1 via RdChan=0, RdSel=0.
- Stuffed data accepted, violation caught:
  - Inside a frame, 1,1,1,1,1,0,1 produces no StuffErr.
  - 1,1,1,1,1,1 produces StuffErr 1 cycle after the 6th one and no AbortDet.
  - A 7th one produces AbortDet.
- Abort with AbortReq=1: drive eight ones inside a frame. StuffErr stays 0 and AbortDet fires once. The abort counter reads 1 and the stuff counter reads 0.
- Idle check (IDLE_GAP=8):
  - FrameActive falls, then Line=0 at cycle 5: no IdleErr.
  - Line=0 at cycle 9: IdleErr pulses once.
- Saturation and clear (CNT_W=2):
  - 5 flags leave the flag counter at 3.
  - CntClr coinciding with a 6th flag's increment leaves the counter at 0.
  - Reset mid-frame zeroes all outputs immediately.
- With HDLC_MON_IRQ_EN and IrqMask=4'b0010:
  - An event on channel 0 leaves Irq=0.
  - An event on channel 1 gives Irq=1 on the cycle after the pulse.
  - IrqAck clears Irq. Without the macro, Irq stays 0 throughout.
